// File: rtl/fifo_stream_ctrl_if.sv
// fifo_stream_ctrl_if: strobe/data inputs and status outputs of fifo_stream_ctrl.
// master = producer/consumer side, slave = the FIFO itself.
interface fifo_stream_ctrl_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 10
);
    logic                  wr_clk;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_fifo_in;
    logic                  rd_clk;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_fifo_out;
    logic                  data_valid;
    logic [ADDR_WIDTH:0]   level;
    logic                  wr_full;
    logic                  rd_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_clk, wr_en, data_fifo_in, rd_clk, rd_en,
        input  data_fifo_out, data_valid, level, wr_full, rd_empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr_clk, wr_en, data_fifo_in, rd_clk, rd_en,
        output data_fifo_out, data_valid, level, wr_full, rd_empty,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_stream_ctrl.sv
// fifo_stream_ctrl: single-clock circular FIFO whose writes/reads are rising edges of strobes.
// Define FIFO_FWFT_EN for first-word fall-through output; default is a registered 1-cycle read.
module fifo_stream_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1000,
    parameter int AFULL_TH   = 992,
    parameter int AEMPTY_TH  = 8,
    parameter int BATCH_MODE = 0
) (
    input logic               clk_100M,
    input logic               rst,
    input logic               clr,
    fifo_stream_ctrl_if.slave bus
);
    typedef enum logic {FILL, DRAIN} phase_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_LVL  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_LVL  = (ADDR_WIDTH + 1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_LVL = (ADDR_WIDTH + 1)'(AEMPTY_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   level_q, level_next;
    logic wr_full_q, rd_empty_q, almost_full_q, almost_empty_q;
    logic overflow_q, underflow_q;
    logic wr_clk_pre, rd_clk_pre, armed;
    phase_t phase;
    logic wr_ev, rd_ev, wr_phase, rd_phase, wr_acc, rd_acc;

    // armed stays low for the first cycle after reset so a strobe already high is not an edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        level_next = level_q;
        wr_ev      = armed & bus.wr_clk & ~wr_clk_pre & bus.wr_en;
        rd_ev      = armed & bus.rd_clk & ~rd_clk_pre & bus.rd_en;
        wr_phase   = (BATCH_MODE == 0) || (phase == FILL);
        rd_phase   = (BATCH_MODE == 0) || (phase == DRAIN);
        wr_acc     = wr_ev & wr_phase & ~wr_full_q;
        rd_acc     = rd_ev & rd_phase & ~rd_empty_q;
        case ({wr_acc, rd_acc})
            2'b10:   level_next = level_q + 1'b1;
            2'b01:   level_next = level_q - 1'b1;
            default: level_next = level_q;
        endcase
    end

    // NOTE: the storage array has no reset; only pointers and flags define its contents.
    always_ff @(posedge clk_100M) begin
        if (wr_acc) mem[wr_ptr] <= bus.data_fifo_in;
    end

`ifndef FIFO_FWFT_EN
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dv_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_100M) begin
        armed <= ~rst;
        if (rst || clr) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level_q        <= '0;
            wr_full_q      <= 1'b0;
            rd_empty_q     <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            wr_clk_pre     <= 1'b0;
            rd_clk_pre     <= 1'b0;
            phase          <= FILL;
`ifndef FIFO_FWFT_EN
            dout_q         <= '0;
            dv_q           <= 1'b0;
`endif
        end else begin
            wr_clk_pre     <= bus.wr_clk;
            rd_clk_pre     <= bus.rd_clk;
            if (wr_acc) wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
            level_q        <= level_next;
            wr_full_q      <= (level_next == DEPTH_LVL);
            rd_empty_q     <= (level_next == '0);
            almost_full_q  <= (level_next >= AFULL_LVL);
            almost_empty_q <= (level_next <= AEMPTY_LVL);
            if (wr_ev && wr_phase && wr_full_q)  overflow_q  <= 1'b1;
            if (rd_ev && rd_phase && rd_empty_q) underflow_q <= 1'b1;
            if (BATCH_MODE != 0) begin
                case (phase)
                    FILL:    if (level_next == DEPTH_LVL) phase <= DRAIN;
                    DRAIN:   if (level_next == '0)        phase <= FILL;
                    default: phase <= FILL;
                endcase
            end
`ifndef FIFO_FWFT_EN
            dv_q <= rd_acc;
            if (rd_acc) dout_q <= mem[rd_ptr];
`endif
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.data_fifo_out = rd_empty_q ? '0 : mem[rd_ptr];
    assign bus.data_valid    = ~rd_empty_q;
`else
    assign bus.data_fifo_out = dout_q;
    assign bus.data_valid    = dv_q;
`endif

    assign bus.level        = level_q;
    assign bus.wr_full      = wr_full_q;
    assign bus.rd_empty     = rd_empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// tb_fifo_stream_ctrl: directed tests for fifo_stream_ctrl, streaming and batch instances.
// Expectations follow FIFO_FWFT_EN when the bench is built with that macro.
module tb_fifo_stream_ctrl;
    logic clk_100M = 1'b0;
    logic rst      = 1'b1;
    logic clr      = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    fifo_stream_ctrl_if #(.DATA_WIDTH(12), .ADDR_WIDTH(10)) s_if ();
    fifo_stream_ctrl_if #(.DATA_WIDTH(12), .ADDR_WIDTH(10)) b_if ();

    fifo_stream_ctrl #(.BATCH_MODE(0)) dut_s (
        .clk_100M (clk_100M),
        .rst      (rst),
        .clr      (clr),
        .bus      (s_if.slave)
    );

    fifo_stream_ctrl #(.BATCH_MODE(1)) dut_b (
        .clk_100M (clk_100M),
        .rst      (rst),
        .clr      (clr),
        .bus      (b_if.slave)
    );

    always #5 clk_100M = ~clk_100M;

    // One strobe edge on the selected instance; returns at the falling edge after the event cycle.
    task automatic pulse(input bit bat, input bit w, input bit r, input logic [11:0] d);
        @(negedge clk_100M);
        if (bat) begin
            b_if.wr_clk = w; b_if.wr_en = w; b_if.rd_clk = r; b_if.rd_en = r; b_if.data_fifo_in = d;
        end else begin
            s_if.wr_clk = w; s_if.wr_en = w; s_if.rd_clk = r; s_if.rd_en = r; s_if.data_fifo_in = d;
        end
        @(negedge clk_100M);
        if (bat) begin
            b_if.wr_clk = 1'b0; b_if.wr_en = 1'b0; b_if.rd_clk = 1'b0; b_if.rd_en = 1'b0;
        end else begin
            s_if.wr_clk = 1'b0; s_if.wr_en = 1'b0; s_if.rd_clk = 1'b0; s_if.rd_en = 1'b0;
        end
    endtask

    task automatic do_clr();
        @(negedge clk_100M);
        clr = 1'b1;
        @(negedge clk_100M);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        // Write strobe held high across reset release must not create an event.
        s_if.wr_clk = 1'b1; s_if.wr_en = 1'b1; s_if.data_fifo_in = 12'h3C3;
        repeat (3) @(negedge clk_100M);
        rst = 1'b0;
        repeat (3) @(negedge clk_100M);
        checks++; if (s_if.level !== 11'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", s_if.level); end
        checks++; if (s_if.rd_empty !== 1'b1 || s_if.almost_empty !== 1'b1) begin
            errors++; $display("FAIL reset_empty_flags got=%b%b exp=11", s_if.rd_empty, s_if.almost_empty); end
        checks++; if (s_if.wr_full !== 1'b0 || s_if.almost_full !== 1'b0) begin
            errors++; $display("FAIL reset_full_flags got=%b%b exp=00", s_if.wr_full, s_if.almost_full); end
        checks++; if (s_if.overflow !== 1'b0 || s_if.underflow !== 1'b0) begin
            errors++; $display("FAIL reset_err_flags got=%b%b exp=00", s_if.overflow, s_if.underflow); end
        checks++; if (s_if.data_fifo_out !== 12'h000 || s_if.data_valid !== 1'b0) begin
            errors++; $display("FAIL reset_data got=%h/%b exp=000/0", s_if.data_fifo_out, s_if.data_valid); end
        checks++; if (b_if.level !== 11'd0 || b_if.rd_empty !== 1'b1) begin
            errors++; $display("FAIL reset_batch got=%0d/%b exp=0/1", b_if.level, b_if.rd_empty); end
        s_if.wr_clk = 1'b0; s_if.wr_en = 1'b0;
        @(negedge clk_100M);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1, 1'b0, 12'(i + 1));
            checks++; if (s_if.level !== 11'(i + 1)) begin
                errors++; $display("FAIL basic_wr_level got=%0d exp=%0d", s_if.level, i + 1); end
        end
        checks++; if (s_if.rd_empty !== 1'b0) begin errors++; $display("FAIL basic_not_empty got=%b exp=0", s_if.rd_empty); end
        for (int i = 0; i < 3; i++) begin
`ifdef FIFO_FWFT_EN
            checks++; if (s_if.data_fifo_out !== 12'(i + 1) || s_if.data_valid !== 1'b1) begin
                errors++; $display("FAIL basic_head got=%h/%b exp=%h/1", s_if.data_fifo_out, s_if.data_valid, 12'(i + 1)); end
            pulse(1'b0, 1'b0, 1'b1, 12'h000);
`else
            pulse(1'b0, 1'b0, 1'b1, 12'h000);
            checks++; if (s_if.data_fifo_out !== 12'(i + 1) || s_if.data_valid !== 1'b1) begin
                errors++; $display("FAIL basic_rd_data got=%h/%b exp=%h/1", s_if.data_fifo_out, s_if.data_valid, 12'(i + 1)); end
            @(negedge clk_100M);
            checks++; if (s_if.data_valid !== 1'b0) begin errors++; $display("FAIL basic_dv_pulse got=%b exp=0", s_if.data_valid); end
`endif
            checks++; if (s_if.level !== 11'(2 - i)) begin
                errors++; $display("FAIL basic_rd_level got=%0d exp=%0d", s_if.level, 2 - i); end
        end
        checks++; if (s_if.rd_empty !== 1'b1) begin errors++; $display("FAIL basic_empty_again got=%b exp=1", s_if.rd_empty); end
    endtask

    task automatic test_underflow();
`ifdef FIFO_FWFT_EN
        logic [11:0] exp_out = 12'h000;
`else
        logic [11:0] exp_out = 12'h003;
`endif
        pulse(1'b0, 1'b0, 1'b1, 12'h000);
        checks++; if (s_if.underflow !== 1'b1) begin errors++; $display("FAIL underflow_flag got=%b exp=1", s_if.underflow); end
        checks++; if (s_if.data_fifo_out !== exp_out || s_if.data_valid !== 1'b0) begin
            errors++; $display("FAIL underflow_data got=%h/%b exp=%h/0", s_if.data_fifo_out, s_if.data_valid, exp_out); end
        checks++; if (s_if.level !== 11'd0 || s_if.overflow !== 1'b0) begin
            errors++; $display("FAIL underflow_level got=%0d/%b exp=0/0", s_if.level, s_if.overflow); end
    endtask

    task automatic test_clr();
        pulse(1'b0, 1'b1, 1'b0, 12'h111);
        pulse(1'b0, 1'b1, 1'b0, 12'h222);
        checks++; if (s_if.level !== 11'd2) begin errors++; $display("FAIL clr_pre_level got=%0d exp=2", s_if.level); end
        do_clr();
        checks++; if (s_if.level !== 11'd0 || s_if.rd_empty !== 1'b1 || s_if.almost_empty !== 1'b1) begin
            errors++; $display("FAIL clr_level got=%0d/%b%b exp=0/11", s_if.level, s_if.rd_empty, s_if.almost_empty); end
        checks++; if (s_if.underflow !== 1'b0 || s_if.data_fifo_out !== 12'h000 || s_if.data_valid !== 1'b0) begin
            errors++; $display("FAIL clr_outputs got=%b/%h/%b exp=0/000/0", s_if.underflow, s_if.data_fifo_out, s_if.data_valid); end
    endtask

    task automatic test_write_to_read();
        @(negedge clk_100M);
        s_if.wr_clk = 1'b1; s_if.wr_en = 1'b1; s_if.data_fifo_in = 12'hABC;
        @(negedge clk_100M);
        s_if.wr_clk = 1'b0; s_if.wr_en = 1'b0; s_if.rd_clk = 1'b1; s_if.rd_en = 1'b1;
`ifdef FIFO_FWFT_EN
        checks++; if (s_if.data_fifo_out !== 12'hABC || s_if.data_valid !== 1'b1) begin
            errors++; $display("FAIL fwft_fallthrough got=%h/%b exp=abc/1", s_if.data_fifo_out, s_if.data_valid); end
`endif
        @(negedge clk_100M);
        s_if.rd_clk = 1'b0; s_if.rd_en = 1'b0;
`ifndef FIFO_FWFT_EN
        checks++; if (s_if.data_fifo_out !== 12'hABC || s_if.data_valid !== 1'b1) begin
            errors++; $display("FAIL w2r_data got=%h/%b exp=abc/1", s_if.data_fifo_out, s_if.data_valid); end
`endif
        checks++; if (s_if.level !== 11'd0 || s_if.underflow !== 1'b0) begin
            errors++; $display("FAIL w2r_level got=%0d/%b exp=0/0", s_if.level, s_if.underflow); end
    endtask

    task automatic test_hold_high();
        @(negedge clk_100M);
        s_if.wr_clk = 1'b1; s_if.wr_en = 1'b1; s_if.data_fifo_in = 12'h123;
        repeat (5) @(negedge clk_100M);
        s_if.wr_clk = 1'b0; s_if.wr_en = 1'b0;
        @(negedge clk_100M);
        checks++; if (s_if.level !== 11'd1) begin errors++; $display("FAIL hold_high_level got=%0d exp=1", s_if.level); end
        do_clr();
    endtask

    task automatic test_full();
        for (int i = 0; i < 1000; i++) begin
            pulse(1'b0, 1'b1, 1'b0, 12'(i + 5));
            checks++; if (s_if.level !== 11'(i + 1) || s_if.almost_full !== (i + 1 >= 992) ||
                          s_if.wr_full !== (i + 1 == 1000) || s_if.almost_empty !== (i + 1 <= 8)) begin
                errors++; $display("FAIL fill_flags lvl=%0d af=%b full=%b ae=%b exp_lvl=%0d",
                                   s_if.level, s_if.almost_full, s_if.wr_full, s_if.almost_empty, i + 1); end
        end
        checks++; if (s_if.overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow got=%b exp=0", s_if.overflow); end
        pulse(1'b0, 1'b1, 1'b0, 12'hEEE);
        checks++; if (s_if.overflow !== 1'b1 || s_if.level !== 11'd1000 || s_if.wr_full !== 1'b1) begin
            errors++; $display("FAIL overflow got=%b/%0d/%b exp=1/1000/1", s_if.overflow, s_if.level, s_if.wr_full); end
        do_clr();
        checks++; if (s_if.overflow !== 1'b0 || s_if.level !== 11'd0) begin
            errors++; $display("FAIL clr_after_full got=%b/%0d exp=0/0", s_if.overflow, s_if.level); end
        // Empty with both events: write wins, read flags underflow.
        pulse(1'b0, 1'b1, 1'b1, 12'h7AA);
        checks++; if (s_if.level !== 11'd1 || s_if.underflow !== 1'b1 || s_if.overflow !== 1'b0) begin
            errors++; $display("FAIL empty_both got=%0d/%b/%b exp=1/1/0", s_if.level, s_if.underflow, s_if.overflow); end
`ifndef FIFO_FWFT_EN
        checks++; if (s_if.data_valid !== 1'b0) begin errors++; $display("FAIL empty_both_dv got=%b exp=0", s_if.data_valid); end
`endif
        for (int i = 0; i < 999; i++) pulse(1'b0, 1'b1, 1'b0, 12'(i + 5));
        checks++; if (s_if.level !== 11'd1000 || s_if.wr_full !== 1'b1) begin
            errors++; $display("FAIL refill got=%0d/%b exp=1000/1", s_if.level, s_if.wr_full); end
        // Full with both events: read wins, write flags overflow.
`ifdef FIFO_FWFT_EN
        checks++; if (s_if.data_fifo_out !== 12'h7AA) begin errors++; $display("FAIL full_both_head got=%h exp=7aa", s_if.data_fifo_out); end
`endif
        pulse(1'b0, 1'b1, 1'b1, 12'hFFF);
        checks++; if (s_if.level !== 11'd999 || s_if.overflow !== 1'b1 || s_if.wr_full !== 1'b0) begin
            errors++; $display("FAIL full_both got=%0d/%b/%b exp=999/1/0", s_if.level, s_if.overflow, s_if.wr_full); end
`ifndef FIFO_FWFT_EN
        checks++; if (s_if.data_fifo_out !== 12'h7AA || s_if.data_valid !== 1'b1) begin
            errors++; $display("FAIL full_both_data got=%h/%b exp=7aa/1", s_if.data_fifo_out, s_if.data_valid); end
`endif
        do_clr();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 500; k++) pulse(1'b0, 1'b1, 1'b0, 12'(k));
        checks++; if (s_if.level !== 11'd500) begin errors++; $display("FAIL b2b_prefill got=%0d exp=500", s_if.level); end
        for (int n = 0; n < 1500; n++) begin
`ifdef FIFO_FWFT_EN
            checks++; if (s_if.data_fifo_out !== 12'(n)) begin
                errors++; $display("FAIL b2b_head n=%0d got=%h exp=%h", n, s_if.data_fifo_out, 12'(n)); end
            pulse(1'b0, 1'b1, 1'b1, 12'(500 + n));
`else
            pulse(1'b0, 1'b1, 1'b1, 12'(500 + n));
            checks++; if (s_if.data_fifo_out !== 12'(n) || s_if.data_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_data n=%0d got=%h/%b exp=%h/1", n, s_if.data_fifo_out, s_if.data_valid, 12'(n)); end
`endif
            checks++; if (s_if.level !== 11'd500) begin
                errors++; $display("FAIL b2b_level n=%0d got=%0d exp=500", n, s_if.level); end
        end
        checks++; if (s_if.overflow !== 1'b0 || s_if.underflow !== 1'b0) begin
            errors++; $display("FAIL b2b_err_flags got=%b%b exp=00", s_if.overflow, s_if.underflow); end
        do_clr();
    endtask

    task automatic test_batch();
        pulse(1'b1, 1'b0, 1'b1, 12'h000);
        checks++; if (b_if.level !== 11'd0 || b_if.underflow !== 1'b0) begin
            errors++; $display("FAIL batch_fill_rd_empty got=%0d/%b exp=0/0", b_if.level, b_if.underflow); end
        for (int i = 0; i < 1000; i++) begin
            pulse(1'b1, 1'b1, 1'b0, 12'(i + 1));
            if (i == 9) begin
                pulse(1'b1, 1'b0, 1'b1, 12'h000);
                checks++; if (b_if.level !== 11'd10) begin
                    errors++; $display("FAIL batch_fill_rd_ignored got=%0d exp=10", b_if.level); end
            end
        end
        checks++; if (b_if.level !== 11'd1000 || b_if.wr_full !== 1'b1) begin
            errors++; $display("FAIL batch_full got=%0d/%b exp=1000/1", b_if.level, b_if.wr_full); end
        pulse(1'b1, 1'b1, 1'b0, 12'hDDD);
        checks++; if (b_if.level !== 11'd1000 || b_if.overflow !== 1'b0) begin
            errors++; $display("FAIL batch_drain_wr_ignored got=%0d/%b exp=1000/0", b_if.level, b_if.overflow); end
        for (int i = 0; i < 1000; i++) begin
            if (i == 999) begin
                pulse(1'b1, 1'b1, 1'b0, 12'hDDD);
                checks++; if (b_if.level !== 11'd1) begin
                    errors++; $display("FAIL batch_drain_wr_late got=%0d exp=1", b_if.level); end
            end
`ifdef FIFO_FWFT_EN
            checks++; if (b_if.data_fifo_out !== 12'(i + 1)) begin
                errors++; $display("FAIL batch_head i=%0d got=%h exp=%h", i, b_if.data_fifo_out, 12'(i + 1)); end
            pulse(1'b1, 1'b0, 1'b1, 12'h000);
`else
            pulse(1'b1, 1'b0, 1'b1, 12'h000);
            checks++; if (b_if.data_fifo_out !== 12'(i + 1) || b_if.data_valid !== 1'b1) begin
                errors++; $display("FAIL batch_data i=%0d got=%h/%b exp=%h/1", i, b_if.data_fifo_out, b_if.data_valid, 12'(i + 1)); end
`endif
            checks++; if (b_if.level !== 11'(999 - i)) begin
                errors++; $display("FAIL batch_drain_level i=%0d got=%0d exp=%0d", i, b_if.level, 999 - i); end
        end
        checks++; if (b_if.rd_empty !== 1'b1 || b_if.underflow !== 1'b0) begin
            errors++; $display("FAIL batch_drained got=%b/%b exp=1/0", b_if.rd_empty, b_if.underflow); end
        pulse(1'b1, 1'b0, 1'b1, 12'h000);
        checks++; if (b_if.underflow !== 1'b0 || b_if.level !== 11'd0) begin
            errors++; $display("FAIL batch_refill_rd_ignored got=%b/%0d exp=0/0", b_if.underflow, b_if.level); end
        pulse(1'b1, 1'b1, 1'b0, 12'h0AB);
        checks++; if (b_if.level !== 11'd1) begin errors++; $display("FAIL batch_back_to_fill got=%0d exp=1", b_if.level); end
    endtask

    initial begin
        s_if.wr_clk = 1'b0; s_if.wr_en = 1'b0; s_if.rd_clk = 1'b0; s_if.rd_en = 1'b0; s_if.data_fifo_in = '0;
        b_if.wr_clk = 1'b0; b_if.wr_en = 1'b0; b_if.rd_clk = 1'b0; b_if.rd_en = 1'b0; b_if.data_fifo_in = '0;
        test_reset();
        test_basic();
        test_underflow();
        test_clr();
        test_write_to_read();
        test_hold_high();
        test_full();
        test_back_to_back();
        test_batch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        repeat (100000) @(posedge clk_100M);
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
